rr_arbiter8_ctrl: RTL and testbench

Round-robin arbiter that shares one 8-way resource among eight requesters. It selects one owner at a time and holds the grant until the owner releases it or a hold timeout expires. It produces the grant as a 3-bit index plus an active-low enable, and decodes these into a one-hot grant vector. It sits in front of the team's 3-to-8 decode path, so downstream select logic sees exactly one active line per grant.

---
 rtl/rr_arbiter8_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter8_ctrl_if.sv | 40 ++++
 rtl/rr_arbiter8_ctrl_dec.sv | 20 ++
 rtl/rr_arbiter8_ctrl.sv | 112 +++++++++++
 tb/tb_rr_arbiter8_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter8_ctrl_pkg
// Brief   : Shared types and constants for the 8-way round-robin arbiter
//           family (state encoding, requester count, index width).
// Revision: 1.0 - initial release
// ============================================================================
package rr_arbiter8_ctrl_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef logic [N_REQ-1:0] req_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter8_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter8_ctrl_if
// Brief   : Request/grant bundle between requesters and the round-robin
//           arbiter. master = requester side, slave = arbiter side.
// Revision: 1.0 - initial release
// ============================================================================
interface rr_arbiter8_ctrl_if;
   import rr_arbiter8_ctrl_pkg::*;

   req_t req;
   logic rel;
   req_t gnt;
   idx_t gnt_idx;
   logic gnt_en_n;
   logic busy;
   logic timeout;

   modport master (
      output req,
      output rel,
      input  gnt,
      input  gnt_idx,
      input  gnt_en_n,
      input  busy,
      input  timeout
   );

   modport slave (
      input  req,
      input  rel,
      output gnt,
      output gnt_idx,
      output gnt_en_n,
      output busy,
      output timeout
   );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter8_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module  : decoder3x8_active_low
// Brief   : 3-to-8 one-hot decoder with active-low enable. All outputs are
//           zero while en is high, so the result can never be multi-hot.
// Revision: 1.0 - initial release
// ============================================================================
module decoder3x8_active_low (
   input  logic       en,
   input  logic [2:0] i,
   output logic [7:0] d
);

   // One output line per code; each line is a compare against its own index
   for (genvar k = 0; k < 8; k++) begin : g_dec
      assign d[k] = !en && (i == 3'(k));
   end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter8_ctrl
// Brief   : 8-way round-robin arbiter. Grants one owner at a time, holds the
//           grant until release, owner request drop, or hold timeout, then
//           spends one idle cycle before re-arbitrating from ptr onward.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter8_ctrl
   import rr_arbiter8_ctrl_pkg::*;
#(
   parameter int HOLD_MAX = 15,
   parameter int CW       = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   rr_arbiter8_ctrl_if.slave   bus
);

   // Last counter value before the timeout fires; unused when HOLD_MAX is 0
   localparam int            c_hold_last_i = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
   localparam logic [CW-1:0] c_hold_last   = CW'(c_hold_last_i);

   state_t        r_state;
   idx_t          r_ptr;
   idx_t          r_gnt_idx;
   logic [CW-1:0] r_hold_cnt;
   logic          r_busy;
   logic          r_gnt_en_n;
   logic          r_timeout;

   idx_t          w_pick;
   logic          w_expire;
   logic          w_drop;
   logic          w_release;
   req_t          w_gnt;

   // First requester at or after p, wrapping past index 7 back to 0
   function automatic idx_t rr_pick(input req_t r, input idx_t p);
      idx_t k;
      idx_t w;
      logic found;
      w     = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         k = p + idx_t'(i);
         if (!found && r[k]) begin
            w     = k;
            found = 1'b1;
         end
      end
      return w;
   endfunction

   assign w_pick    = rr_pick(bus.req, r_ptr);
   assign w_expire  = (HOLD_MAX != 0) && (r_hold_cnt == c_hold_last);
   assign w_drop    = !bus.req[r_gnt_idx];
   assign w_release = bus.rel || w_drop || w_expire;

   // Arbitration FSM with registered grant index, enable, busy and timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_gnt_idx  <= '0;
         r_hold_cnt <= '0;
         r_busy     <= 1'b0;
         r_gnt_en_n <= 1'b1;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_timeout <= 1'b0;
               if (|bus.req) begin
                  r_gnt_idx  <= w_pick;
                  r_hold_cnt <= '0;
                  r_busy     <= 1'b1;
                  r_gnt_en_n <= 1'b0;
                  r_state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  r_ptr      <= r_gnt_idx + 3'd1;
                  r_busy     <= 1'b0;
                  r_gnt_en_n <= 1'b1;
                  // Timeout is flagged only when the counter alone ended the grant
                  r_timeout  <= w_expire && !bus.rel && !w_drop;
                  r_state    <= ST_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt + CW'(1);
                  r_timeout  <= 1'b0;
               end
            end
         endcase
      end
   end

   decoder3x8_active_low u_dec (
      .en (r_gnt_en_n),
      .i  (r_gnt_idx),
      .d  (w_gnt)
   );

   assign bus.gnt      = w_gnt;
   assign bus.gnt_idx  = r_gnt_idx;
   assign bus.gnt_en_n = r_gnt_en_n;
   assign bus.busy     = r_busy;
   assign bus.timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_arbiter8_ctrl
// Brief   : Self-checking bench for rr_arbiter8_ctrl (HOLD_MAX=4). Each test
//           drives one cycle at a time and queues the outputs expected after
//           the next rising edge; a monitor compares them on the falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8_ctrl;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;

   typedef struct {
      int         cyc;
      logic [7:0] gnt;
      logic       to;
      string      tag;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   wi;

   rr_arbiter8_ctrl_if bus ();

   rr_arbiter8_ctrl #(
      .HOLD_MAX (4),
      .CW       (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: pops every entry due for the current cycle
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_checks++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s missed: due cycle %0d, seen at %0d", e.tag, e.cyc, cyc);
         end else begin
            if (bus.gnt !== e.gnt) begin
               n_fail++;
               $display("FAIL %s gnt: got %h want %h (cycle %0d)", e.tag, bus.gnt, e.gnt, cyc);
            end
            n_checks++;
            if (bus.timeout !== e.to) begin
               n_fail++;
               $display("FAIL %s timeout: got %b want %b (cycle %0d)", e.tag, bus.timeout, e.to, cyc);
            end
            n_checks++;
            if (bus.busy !== (|e.gnt) || bus.gnt_en_n !== !(|e.gnt)) begin
               n_fail++;
               $display("FAIL %s busy/en_n: got %b/%b want %b/%b", e.tag, bus.busy, bus.gnt_en_n,
                        |e.gnt, !(|e.gnt));
            end
            if (e.gnt != 8'h00) begin
               wi = 0;
               for (int i = 0; i < 8; i++) if (e.gnt[i]) wi = i;
               n_checks++;
               if (bus.gnt_idx !== 3'(wi)) begin
                  n_fail++;
                  $display("FAIL %s gnt_idx: got %0d want %0d", e.tag, bus.gnt_idx, wi);
               end
            end
         end
      end
   end

   // Drive one cycle of stimulus and queue what the next edge must produce
   task automatic step(input logic [7:0] r, input logic rl, input logic [7:0] eg,
                       input logic et, input string tag);
      bus.req = r;
      bus.rel = rl;
      sb.push_back('{cyc: cyc + 1, gnt: eg, to: et, tag: tag});
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      bus.req = 8'h00;
      bus.rel = 1'b0;
      @(posedge clk);
      #2;
      n_checks++;
      if (bus.gnt !== 8'h00 || bus.gnt_idx !== 3'd0 || bus.busy !== 1'b0 ||
          bus.gnt_en_n !== 1'b1 || bus.timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got gnt=%h idx=%0d busy=%b en_n=%b to=%b want 00/0/0/1/0",
                  bus.gnt, bus.gnt_idx, bus.busy, bus.gnt_en_n, bus.timeout);
      end
      rst_n = 1'b1;
      step(8'h00, 1'b0, 8'h00, 1'b0, "reset_idle");
   endtask

   task automatic test_single();
      step(8'h08, 1'b0, 8'h08, 1'b0, "single_grant");
      step(8'h08, 1'b0, 8'h08, 1'b0, "single_hold");
      step(8'h00, 1'b0, 8'h00, 1'b0, "single_drop");
      n_checks++;
      if (bus.gnt_idx !== 3'd3) begin
         n_fail++;
         $display("FAIL single_idx_held: got %0d want 3", bus.gnt_idx);
      end
      // ptr is now 4: requester 4 wins over requester 0
      step(8'h11, 1'b0, 8'h10, 1'b0, "single_ptr4");
      step(8'h11, 1'b1, 8'h00, 1'b0, "single_rel");
      step(8'h00, 1'b0, 8'h00, 1'b0, "single_idle");
   endtask

   task automatic test_rotation();
      logic [7:0] g;
      // ptr starts at 5, so the order is 5,6,7,0,...,5 with one idle between
      for (int n = 0; n < 9; n++) begin
         g = 8'b1 << ((5 + n) % 8);
         step(8'hFF, 1'b0, g, 1'b0, "rot_grant");
         step(8'hFF, 1'b0, g, 1'b0, "rot_hold");
         step(8'hFF, 1'b1, 8'h00, 1'b0, "rot_rel");
      end
   endtask

   task automatic test_wrap();
      // ptr=6 after owner 5: nothing at or above 6, wrap to 0
      step(8'h03, 1'b0, 8'h01, 1'b0, "wrap_to0");
      step(8'h03, 1'b1, 8'h00, 1'b0, "wrap_rel0");
      step(8'h03, 1'b0, 8'h02, 1'b0, "wrap_to1");
      step(8'h03, 1'b1, 8'h00, 1'b0, "wrap_rel1");
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 4; i++) step(8'h10, 1'b0, 8'h10, 1'b0, "to_hold");
      step(8'h10, 1'b0, 8'h00, 1'b1, "to_fire");
      n_checks++;
      if (bus.timeout !== 1'b1 || bus.gnt !== 8'h00) begin
         n_fail++;
         $display("FAIL to_pulse: got to=%b gnt=%h want 1/00", bus.timeout, bus.gnt);
      end
      step(8'h10, 1'b0, 8'h10, 1'b0, "to_regrant");
      for (int i = 0; i < 3; i++) step(8'h11, 1'b0, 8'h10, 1'b0, "to_hold2");
      step(8'h11, 1'b0, 8'h00, 1'b1, "to_fire2");
      step(8'h11, 1'b0, 8'h01, 1'b0, "to_other");
   endtask

   task automatic test_simultaneous();
      step(8'h01, 1'b0, 8'h01, 1'b0, "sim_hold1");
      step(8'hFF, 1'b0, 8'h01, 1'b0, "sim_others_ff");
      step(8'h81, 1'b0, 8'h01, 1'b0, "sim_others_81");
      step(8'h01, 1'b1, 8'h00, 1'b0, "sim_rel_expire");
      step(8'h00, 1'b0, 8'h00, 1'b0, "sim_idle");
      for (int i = 0; i < 4; i++) step(8'h02, 1'b0, 8'h02, 1'b0, "sim_hold_b");
      step(8'h00, 1'b0, 8'h00, 1'b0, "sim_drop_expire");
      step(8'h00, 1'b1, 8'h00, 1'b0, "sim_rel_idle");
      step(8'h04, 1'b0, 8'h04, 1'b0, "sim_after_idle_rel");
      step(8'h04, 1'b1, 8'h00, 1'b0, "sim_rel2");
   endtask

   task automatic test_reset_mid();
      step(8'h20, 1'b0, 8'h20, 1'b0, "mid_grant5");
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.gnt_en_n !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_async_clear: got gnt=%h busy=%b en_n=%b want 00/0/1",
                  bus.gnt, bus.busy, bus.gnt_en_n);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      // ptr is back to 0, so requester 0 beats requester 5
      step(8'h21, 1'b0, 8'h01, 1'b0, "mid_restart");
      step(8'h21, 1'b1, 8'h00, 1'b0, "mid_rel");
   endtask

   initial begin
      cyc      = 0;
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_timeout();
      test_simultaneous();
      test_reset_mid();
      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
